// File: rtl/sdcard_spi_responder.sv
// SPI-mode SD card target: decodes 48-bit command frames, answers R1/R3/R7 and
// streams single-block CMD17 reads from a byte-wide backing store.
`timescale 1ns/1ps

module sdcard_spi_responder #(
    parameter int          INIT_ACMD41 = 2,
    parameter int          NAC_BYTES   = 4,
    parameter logic [31:0] OCR         = 32'hC0FF8000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] mem_lba,
    output logic [8:0]  mem_idx,
    input  logic [7:0]  mem_rdata,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_ready
);

    typedef enum logic [1:0] {HUNT, CMD, RESP} state_t;

    localparam logic [15:0] NAC_W     = 16'(NAC_BYTES);
    localparam logic [15:0] DATA_LAST = 16'(NAC_BYTES + 512);
    localparam logic [15:0] RD_END    = 16'(NAC_BYTES + 515);

    state_t      state, state_next;

    logic [1:0]  cs_sync, sclk_sync, mosi_sync;
    logic        sclk_prev;
    logic        cs_high, mosi_bit, sclk_rise, sclk_fall;

    logic [37:0] cmd_sr;
    logic [5:0]  bit_cnt;
    logic [7:0]  tx_sr;
    logic [39:0] resp_q;
    logic [2:0]  resp_cnt;
    logic        rd_mode;
    logic [15:0] rd_cnt;
    logic [1:0]  load_dly;
    logic        idle, app;
    logic [15:0] acmd_cnt;

    logic        start_seen, frame_done, byte_done, have_more, next_is_data;
    logic [7:0]  next_byte;

    logic [5:0]  frame_idx;
    logic [31:0] frame_arg;
    logic [7:0]  r1;
    logic [39:0] dec_q;
    logic [2:0]  dec_len;
    logic        dec_read, dec_idle, dec_ready, dec_app;
    logic [15:0] dec_acmd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            sclk_sync <= {sclk_sync[0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign cs_high   = cs_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign sclk_rise = !cs_high && sclk_sync[1] && !sclk_prev;
    assign sclk_fall = !cs_high && !sclk_sync[1] && sclk_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= HUNT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_high) begin
            state_next = HUNT;
        end else begin
            case (state)
                HUNT:    if (start_seen) state_next = CMD;
                CMD:     if (frame_done) state_next = RESP;
                RESP:    if (byte_done && !have_more) state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    // Read-phase byte selection: rd_cnt indexes the next byte after the R1 byte.
    always_comb begin
        start_seen   = (state == HUNT) && sclk_rise && !mosi_bit;
        frame_done   = (state == CMD) && sclk_rise && (bit_cnt == 6'd46);
        byte_done    = (state == RESP) && sclk_rise && (bit_cnt == 6'd7);
        have_more    = (resp_cnt != 3'd0) || (rd_mode && (rd_cnt < RD_END));
        next_byte    = 8'hFF;
        next_is_data = 1'b0;
        if (rd_cnt == NAC_W) begin
            next_byte = 8'hFE;
        end else if ((rd_cnt > NAC_W) && (rd_cnt <= DATA_LAST)) begin
            next_is_data = 1'b1;
        end
    end

    assign frame_idx = cmd_sr[37:32];
    assign frame_arg = cmd_sr[31:0];
    assign r1        = {7'b0, idle};

    always_comb begin
        dec_q     = {r1 | 8'h04, 32'hFFFF_FFFF};
        dec_len   = 3'd1;
        dec_read  = 1'b0;
        dec_idle  = idle;
        dec_ready = card_ready;
        dec_acmd  = acmd_cnt;
        dec_app   = 1'b0;
        case (frame_idx)
            6'd0: begin
                dec_idle  = 1'b1;
                dec_ready = 1'b0;
                dec_acmd  = 16'd0;
                dec_q     = {8'h01, 32'hFFFF_FFFF};
            end
            6'd8: begin
                dec_q   = {r1, 16'h0000, 4'h0, frame_arg[11:0]};
                dec_len = 3'd5;
            end
            6'd55: begin
                dec_app = 1'b1;
                dec_q   = {r1, 32'hFFFF_FFFF};
            end
            6'd41: begin
                if (app) begin
                    if (acmd_cnt < 16'(INIT_ACMD41)) begin
                        dec_acmd = acmd_cnt + 16'd1;
                        dec_q    = {8'h01, 32'hFFFF_FFFF};
                    end else begin
                        dec_idle  = 1'b0;
                        dec_ready = 1'b1;
                        dec_q     = {8'h00, 32'hFFFF_FFFF};
                    end
                end
            end
            6'd58: begin
                dec_q   = {r1, OCR};
                dec_len = 3'd5;
            end
            6'd17: begin
                if (!idle) begin
                    dec_q    = {8'h00, 32'hFFFF_FFFF};
                    dec_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Data bytes are fetched three clocks after mem_idx moves, so the
    // backing store's two-clock latency is met before the next SCLK fall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spi_miso   <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_index  <= 6'd0;
            cmd_arg    <= 32'd0;
            mem_lba    <= 32'd0;
            mem_idx    <= 9'd0;
            card_ready <= 1'b0;
            idle       <= 1'b1;
            app        <= 1'b0;
            acmd_cnt   <= 16'd0;
            cmd_sr     <= 38'd0;
            bit_cnt    <= 6'd0;
            tx_sr      <= 8'hFF;
            resp_q     <= 40'd0;
            resp_cnt   <= 3'd0;
            rd_mode    <= 1'b0;
            rd_cnt     <= 16'd0;
            load_dly   <= 2'd0;
        end else begin
            cmd_valid <= 1'b0;
            if (cs_high) begin
                spi_miso <= 1'b1;
                bit_cnt  <= 6'd0;
                resp_cnt <= 3'd0;
                rd_mode  <= 1'b0;
                rd_cnt   <= 16'd0;
                load_dly <= 2'd0;
            end else begin
                case (state)
                    HUNT: begin
                        if (start_seen) bit_cnt <= 6'd0;
                    end
                    CMD: begin
                        if (frame_done) begin
                            cmd_valid  <= 1'b1;
                            cmd_index  <= frame_idx;
                            cmd_arg    <= frame_arg;
                            idle       <= dec_idle;
                            card_ready <= dec_ready;
                            acmd_cnt   <= dec_acmd;
                            app        <= dec_app;
                            tx_sr      <= 8'hFF;
                            resp_q     <= dec_q;
                            resp_cnt   <= dec_len;
                            rd_mode    <= dec_read;
                            rd_cnt     <= 16'd0;
                            bit_cnt    <= 6'd0;
                            if (dec_read) mem_lba <= frame_arg;
                        end else if (sclk_rise) begin
                            if ((bit_cnt >= 6'd1) && (bit_cnt <= 6'd38))
                                cmd_sr <= {cmd_sr[36:0], mosi_bit};
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    RESP: begin
                        if (load_dly != 2'd0) begin
                            load_dly <= load_dly - 2'd1;
                            if (load_dly == 2'd1) tx_sr <= mem_rdata;
                        end
                        if (sclk_fall) begin
                            spi_miso <= tx_sr[7];
                            tx_sr    <= {tx_sr[6:0], 1'b1};
                        end
                        if (sclk_rise) begin
                            bit_cnt <= byte_done ? 6'd0 : bit_cnt + 6'd1;
                        end
                        if (byte_done) begin
                            if (!have_more) begin
                                spi_miso <= 1'b1;
                            end else if (resp_cnt != 3'd0) begin
                                tx_sr    <= resp_q[39:32];
                                resp_q   <= {resp_q[31:0], 8'hFF};
                                resp_cnt <= resp_cnt - 3'd1;
                            end else begin
                                tx_sr  <= next_byte;
                                rd_cnt <= rd_cnt + 16'd1;
                                if (next_is_data) begin
                                    mem_idx  <= rd_cnt[8:0] - 9'(NAC_BYTES + 1);
                                    load_dly <= 2'd3;
                                end
                                if (rd_cnt == DATA_LAST + 16'd1) mem_idx <= 9'd0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdcard_spi_responder.sv
// Directed bench for sdcard_spi_responder: a mode-0 SPI master drives command
// frames and compares every response byte against hand-computed values.
`timescale 1ns/1ps

module tb_sdcard_spi_responder;

    localparam int HALF = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b1;
    logic        spi_miso;
    logic [31:0] mem_lba;
    logic [8:0]  mem_idx;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_d1;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        card_ready;

    int          checks = 0;
    int          errors = 0;
    int          valid_cnt = 0;
    int          frames = 0;
    logic [5:0]  last_idx = 6'd0;

    sdcard_spi_responder #(
        .INIT_ACMD41(2),
        .NAC_BYTES(4),
        .OCR(32'hC0FF8000)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .spi_cs(spi_cs),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .mem_lba(mem_lba),
        .mem_idx(mem_idx),
        .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid),
        .cmd_index(cmd_index),
        .cmd_arg(cmd_arg),
        .card_ready(card_ready)
    );

    always #20 clock = ~clock;

    // Backing store returns the low byte of the index with two clocks of latency.
    always @(posedge clock) begin
        mem_d1    <= mem_idx[7:0];
        mem_rdata <= mem_d1;
    end

    always @(negedge clock) begin
        if (cmd_valid) begin
            valid_cnt++;
            last_idx = cmd_index;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clock);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b1;
    endtask

    task automatic cs_select();
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic cs_release();
        spi_cs = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic apply_stimulus(input logic [5:0] idx, input logic [31:0] arg,
                                  input logic [7:0] crc);
        logic [7:0] rx;
        xfer_byte({2'b01, idx}, rx);
        xfer_byte(arg[31:24], rx);
        xfer_byte(arg[23:16], rx);
        xfer_byte(arg[15:8], rx);
        xfer_byte(arg[7:0], rx);
        xfer_byte(crc, rx);
        frames++;
    endtask

    task automatic read_bytes(input string tag, input int n, input logic [55:0] exp);
        logic [7:0] rx;
        for (int k = 0; k < n; k++) begin
            xfer_byte(8'hFF, rx);
            check_output($sformatf("%s byte%0d", tag, k), {24'd0, rx},
                         {24'd0, exp[55 - 8*k -: 8]});
        end
    endtask

    task automatic read_resp(input string tag, input int n, input logic [55:0] exp);
        read_bytes(tag, n, exp);
        repeat (2) @(negedge clock);
        check_output({tag, " miso idle"}, {31'd0, spi_miso}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " miso"}, {31'd0, spi_miso}, 32'd1);
        check_output({tag, " cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        check_output({tag, " cmd_index"}, {26'd0, cmd_index}, 32'd0);
        check_output({tag, " cmd_arg"}, cmd_arg, 32'd0);
        check_output({tag, " mem_lba"}, mem_lba, 32'd0);
        check_output({tag, " mem_idx"}, {23'd0, mem_idx}, 32'd0);
        check_output({tag, " card_ready"}, {31'd0, card_ready}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx;

        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        cs_select();
        apply_stimulus(6'd0, 32'h0, 8'h95);
        read_resp("cmd0", 2, {16'hFF01, 40'h0});
        check_output("cmd0 valid count", valid_cnt, 32'd1);
        check_output("cmd0 index", {26'd0, last_idx}, 32'd0);
        cs_release();

        cs_select();
        apply_stimulus(6'd8, 32'h0000_01AA, 8'h87);
        read_resp("cmd8", 6, {48'hFF01_0000_01AA, 8'h0});
        check_output("cmd8 index", {26'd0, cmd_index}, 32'd8);
        check_output("cmd8 arg", cmd_arg, 32'h0000_01AA);
        cs_release();

        cs_select();
        apply_stimulus(6'd17, 32'd5, 8'h01);
        read_resp("cmd17 idle", 2, {16'hFF05, 40'h0});
        check_output("cmd17 idle lba", mem_lba, 32'd0);
        cs_release();

        for (int r = 0; r < 3; r++) begin
            cs_select();
            apply_stimulus(6'd55, 32'h0, 8'h65);
            read_resp("cmd55", 2, {16'hFF01, 40'h0});
            cs_release();
            cs_select();
            apply_stimulus(6'd41, 32'h4000_0000, 8'h77);
            read_resp($sformatf("acmd41 #%0d", r), 2,
                      {8'hFF, ((r == 2) ? 8'h00 : 8'h01), 40'h0});
            cs_release();
            check_output($sformatf("card_ready #%0d", r), {31'd0, card_ready},
                         (r == 2) ? 32'd1 : 32'd0);
        end

        cs_select();
        apply_stimulus(6'd58, 32'h0, 8'hFD);
        read_resp("cmd58", 6, {48'hFF00_C0FF_8000, 8'h0});
        cs_release();

        cs_select();
        apply_stimulus(6'd17, 32'd5, 8'h01);
        read_bytes("cmd17 hdr", 7, 56'hFF00_FFFF_FFFF_FE);
        check_output("cmd17 lba", mem_lba, 32'd5);
        for (int i = 0; i < 512; i++) begin
            xfer_byte(8'hFF, rx);
            check_output($sformatf("cmd17 data%0d", i), {24'd0, rx}, {24'd0, 8'(i)});
        end
        read_resp("cmd17 tail", 2, {16'hFFFF, 40'h0});
        check_output("cmd17 idx wrap", {23'd0, mem_idx}, 32'd0);
        cs_release();

        cs_select();
        apply_stimulus(6'd17, 32'd5, 8'h01);
        read_bytes("abort hdr", 7, 56'hFF00_FFFF_FFFF_FE);
        for (int i = 0; i < 20; i++) begin
            xfer_byte(8'hFF, rx);
            check_output($sformatf("abort data%0d", i), {24'd0, rx}, {24'd0, 8'(i)});
        end
        repeat (4) @(negedge clock);
        check_output("abort miso before cs", {31'd0, spi_miso}, 32'd0);
        spi_cs = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("abort miso after cs", {31'd0, spi_miso}, 32'd1);
        check_output("abort card_ready kept", {31'd0, card_ready}, 32'd1);
        check_output("abort mem_idx", {23'd0, mem_idx}, 32'd20);
        repeat (4) @(negedge clock);

        cs_select();
        apply_stimulus(6'd0, 32'h0, 8'h95);
        read_resp("cmd0 again", 2, {16'hFF01, 40'h0});
        check_output("cmd0 clears ready", {31'd0, card_ready}, 32'd0);
        cs_release();

        cs_select();
        apply_stimulus(6'd8, 32'h0000_01AA, 8'h87);
        read_resp("cmd8 again", 6, {48'hFF01_0000_01AA, 8'h0});
        check_output("valid count", valid_cnt, frames);
        xfer_byte(8'h7A, rx);
        xfer_byte(8'h00, rx);
        xfer_byte(8'h00, rx);
        reset_n = 1'b0;
        #1;
        check_reset_values("midframe reset");
        @(negedge clock);
        reset_n = 1'b1;
        cs_release();

        cs_select();
        apply_stimulus(6'd63, 32'h0, 8'h01);
        read_resp("cmd63", 2, {16'hFF05, 40'h0});
        check_output("cmd63 index", {26'd0, cmd_index}, 32'd63);
        check_output("cmd63 valid idx", {26'd0, last_idx}, 32'd63);
        check_output("final valid count", valid_cnt, frames);
        cs_release();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
